// File: rtl/fetch_stall_flush_ctrl_if.sv
// Hazard-control bundle between the hazard unit (master) and the fetch/ID
// consumer (slave). Carries control inputs, fetch data and all registered outputs.
interface fetch_stall_flush_ctrl_if #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 16
);
    logic              PCWrite;
    logic              IFIDWrite;
    logic              Bolha;
    logic              Flush;
    logic [31:0]       JumpTarget;
    logic [31:0]       Instr_in;
    logic [CTRL_W-1:0] Ctrl_in;
    logic [31:0]       PC_out;
    logic [31:0]       IFID_PC;
    logic [31:0]       IFID_Instr;
    logic              IFID_Valid;
    logic [CTRL_W-1:0] IDEX_Ctrl;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport master (
        output PCWrite, IFIDWrite, Bolha, Flush, JumpTarget, Instr_in, Ctrl_in,
        input  PC_out, IFID_PC, IFID_Instr, IFID_Valid, IDEX_Ctrl, StallCount, FlushCount
    );

    modport slave (
        input  PCWrite, IFIDWrite, Bolha, Flush, JumpTarget, Instr_in, Ctrl_in,
        output PC_out, IFID_PC, IFID_Instr, IFID_Valid, IDEX_Ctrl, StallCount, FlushCount
    );
endinterface

// File: rtl/fetch_stall_flush_ctrl.sv
// Applies PCWrite/IFIDWrite/Bolha/Flush to the PC, IF/ID and ID/EX control
// registers, and keeps saturating stall/flush event counters for debug.
module fetch_stall_flush_ctrl #(
    parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
    parameter int unsigned  CTRL_W    = 12,
    parameter int unsigned  CNT_W     = 16,
    parameter logic [31:0]  NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_stall_flush_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]       pc_q,          pc_d;
    logic [31:0]       ifid_pc_q,     ifid_pc_d;
    logic [31:0]       ifid_instr_q,  ifid_instr_d;
    logic              ifid_valid_q,  ifid_valid_d;
    logic [CTRL_W-1:0] idex_ctrl_q,   idex_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;

    // Next-state: flush outranks stall for PC and IF/ID; Bolha only touches ID/EX.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        idex_ctrl_d  = bus.Ctrl_in;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        if (bus.Flush) begin
            pc_d = {bus.JumpTarget[31:2], 2'b00};
        end else if (bus.PCWrite) begin
            pc_d = pc_q + 32'd4;
        end

        if (bus.Flush) begin
            ifid_pc_d    = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (bus.IFIDWrite) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = bus.Instr_in;
            ifid_valid_d = 1'b1;
        end

        // A killed IF/ID entry becomes a bubble one cycle after the flush.
        if (bus.Bolha || !ifid_valid_q) begin
            idex_ctrl_d = '0;
        end

        if (bus.Bolha && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bus.Flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bus.PC_out     = pc_q;
    assign bus.IFID_PC    = ifid_pc_q;
    assign bus.IFID_Instr = ifid_instr_q;
    assign bus.IFID_Valid = ifid_valid_q;
    assign bus.IDEX_Ctrl  = idex_ctrl_q;
    assign bus.StallCount = stall_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_fetch_stall_flush_ctrl.sv
// Bench for fetch_stall_flush_ctrl: directed scenarios plus randomized hazard
// traffic checked against a pipeline-level reference model.
module tb_fetch_stall_flush_ctrl;
    localparam int unsigned CTRL_W  = 12;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fetch_stall_flush_ctrl_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    fetch_stall_flush_ctrl #(
        .RESET_PC (32'h0000_0000),
        .CTRL_W   (CTRL_W),
        .CNT_W    (CNT_W),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of the fetch/decode boundary.
    logic [31:0]       m_pc, m_ifid_pc, m_ifid_instr;
    logic              m_ifid_valid;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_stalls, m_flushes;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0; m_ifid_pc = 32'd0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
        m_ctrl = '0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_edge(input logic pcw, ifw, b, f, input logic [31:0] jt,
                              input logic [CTRL_W-1:0] ctrl);
        logic [31:0] fetched_pc;
        logic        id_had_instr;
        fetched_pc   = m_pc;
        id_had_instr = m_ifid_valid;
        if (f)        m_pc = jt & ~32'd3;
        else if (pcw) m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        if (f) begin
            m_ifid_instr = NOP; m_ifid_pc = 32'd0; m_ifid_valid = 1'b0;
        end else if (ifw) begin
            m_ifid_instr = imem(fetched_pc); m_ifid_pc = fetched_pc; m_ifid_valid = 1'b1;
        end
        m_ctrl = (b || !id_had_instr) ? '0 : ctrl;
        if (b) m_stalls = (m_stalls + 1 > CNT_MAX) ? CNT_MAX : m_stalls + 1;
        if (f) m_flushes = (m_flushes + 1 > CNT_MAX) ? CNT_MAX : m_flushes + 1;
    endtask

    // One clock: drive inputs (instruction memory follows the model PC), edge, settle.
    task automatic cyc(input logic pcw, ifw, b, f, input logic [31:0] jt,
                       input logic [CTRL_W-1:0] ctrl);
        bus.PCWrite = pcw; bus.IFIDWrite = ifw; bus.Bolha = b; bus.Flush = f;
        bus.JumpTarget = jt; bus.Ctrl_in = ctrl; bus.Instr_in = imem(m_pc);
        @(posedge clk);
        model_edge(pcw, ifw, b, f, jt, ctrl);
        #1;
    endtask

    task automatic reset_dut();
        bus.PCWrite = 1'b0; bus.IFIDWrite = 1'b0; bus.Bolha = 1'b0; bus.Flush = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        bus.PCWrite = 1'b0; bus.IFIDWrite = 1'b0; bus.Bolha = 1'b0; bus.Flush = 1'b0;
        bus.JumpTarget = '0; bus.Instr_in = '0; bus.Ctrl_in = '0;
        rst = 1'b1;
        #1;
        tests_run++; if (bus.PC_out !== 32'd0) begin tests_failed++; $display("FAIL reset_pc: got %h exp 0", bus.PC_out); end
        tests_run++; if (bus.IFID_Instr !== NOP) begin tests_failed++; $display("FAIL reset_instr: got %h exp %h", bus.IFID_Instr, NOP); end
        tests_run++; if (bus.IFID_PC !== 32'd0 || bus.IFID_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_ifid: pc %h v %b exp 0/0", bus.IFID_PC, bus.IFID_Valid); end
        tests_run++; if (bus.IDEX_Ctrl !== '0 || bus.StallCount !== '0 || bus.FlushCount !== '0) begin
            tests_failed++; $display("FAIL reset_ctrl_cnt: ctrl %h sc %0d fc %0d exp 0", bus.IDEX_Ctrl, bus.StallCount, bus.FlushCount); end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        logic [CTRL_W-1:0] c;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            c = CTRL_W'($urandom);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, c);
            tests_run++; if (bus.PC_out !== 32'(4 * (k + 1))) begin tests_failed++; $display("FAIL basic_pc%0d: got %h exp %h", k, bus.PC_out, 32'(4 * (k + 1))); end
            tests_run++; if (bus.IFID_Instr !== imem(32'(4 * k)) || bus.IFID_PC !== 32'(4 * k) || bus.IFID_Valid !== 1'b1) begin
                tests_failed++; $display("FAIL basic_ifid%0d: instr %h pc %h v %b exp %h %h 1", k, bus.IFID_Instr, bus.IFID_PC, bus.IFID_Valid, imem(32'(4 * k)), 32'(4 * k)); end
            tests_run++; if (bus.IDEX_Ctrl !== ((k == 0) ? '0 : c)) begin tests_failed++; $display("FAIL basic_ctrl%0d: got %h exp %h", k, bus.IDEX_Ctrl, (k == 0) ? '0 : c); end
        end
    endtask

    task automatic test_load_use();
        logic [CTRL_W-1:0] c;
        reset_dut();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h111);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h222);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 12'h333);
        tests_run++; if (bus.PC_out !== 32'd8) begin tests_failed++; $display("FAIL lu_pc_hold: got %h exp 8", bus.PC_out); end
        tests_run++; if (bus.IFID_Instr !== imem(32'd4) || bus.IFID_PC !== 32'd4 || bus.IFID_Valid !== 1'b1) begin
            tests_failed++; $display("FAIL lu_ifid_hold: instr %h pc %h v %b", bus.IFID_Instr, bus.IFID_PC, bus.IFID_Valid); end
        tests_run++; if (bus.IDEX_Ctrl !== '0 || bus.StallCount !== 4'd1) begin
            tests_failed++; $display("FAIL lu_bubble: ctrl %h sc %0d exp 0/1", bus.IDEX_Ctrl, bus.StallCount); end
        c = 12'h444;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, c);
        tests_run++; if (bus.PC_out !== 32'd12 || bus.IFID_PC !== 32'd8 || bus.IDEX_Ctrl !== c) begin
            tests_failed++; $display("FAIL lu_resume: pc %h ifid_pc %h ctrl %h exp c 8 %h", bus.PC_out, bus.IFID_PC, bus.IDEX_Ctrl, c); end
    endtask

    task automatic test_jump();
        reset_dut();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h0AA);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103, 12'h0BB);
        tests_run++; if (bus.PC_out !== 32'h100) begin tests_failed++; $display("FAIL jump_pc: got %h exp 100", bus.PC_out); end
        tests_run++; if (bus.IFID_Instr !== NOP || bus.IFID_Valid !== 1'b0 || bus.FlushCount !== 4'd1) begin
            tests_failed++; $display("FAIL jump_kill: instr %h v %b fc %0d exp 13/0/1", bus.IFID_Instr, bus.IFID_Valid, bus.FlushCount); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h0CC);
        tests_run++; if (bus.IDEX_Ctrl !== '0) begin tests_failed++; $display("FAIL jump_nop_ctrl: got %h exp 0", bus.IDEX_Ctrl); end
        tests_run++; if (bus.IFID_Instr !== imem(32'h100) || bus.IFID_PC !== 32'h100 || bus.IFID_Valid !== 1'b1) begin
            tests_failed++; $display("FAIL jump_target_fetch: instr %h pc %h v %b", bus.IFID_Instr, bus.IFID_PC, bus.IFID_Valid); end
    endtask

    task automatic test_bolha_flush();
        reset_dut();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h055);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 12'h066);
        tests_run++; if (bus.PC_out !== 32'h40 || bus.IFID_Valid !== 1'b0 || bus.IFID_Instr !== NOP || bus.IFID_PC !== 32'd0) begin
            tests_failed++; $display("FAIL bf_flush: pc %h v %b instr %h ipc %h", bus.PC_out, bus.IFID_Valid, bus.IFID_Instr, bus.IFID_PC); end
        tests_run++; if (bus.IDEX_Ctrl !== '0 || bus.StallCount !== 4'd1 || bus.FlushCount !== 4'd1) begin
            tests_failed++; $display("FAIL bf_ctrl_cnt: ctrl %h sc %0d fc %0d exp 0/1/1", bus.IDEX_Ctrl, bus.StallCount, bus.FlushCount); end
    endtask

    task automatic test_wrap();
        reset_dut();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, '0);
        tests_run++; if (bus.PC_out !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_setup: got %h exp fffffffc", bus.PC_out); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, '0);
        tests_run++; if (bus.PC_out !== 32'd0 || bus.IFID_PC !== 32'hFFFF_FFFC) begin
            tests_failed++; $display("FAIL wrap_pc: pc %h ifid_pc %h exp 0 fffffffc", bus.PC_out, bus.IFID_PC); end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b1, (k < 17) ? 1'b1 : 1'b0, 32'h200, '0);
        tests_run++; if (bus.StallCount !== 4'd15) begin tests_failed++; $display("FAIL sat_stall: got %0d exp 15", bus.StallCount); end
        tests_run++; if (bus.FlushCount !== 4'd15) begin tests_failed++; $display("FAIL sat_flush: got %0d exp 15", bus.FlushCount); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h777);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 12'h777);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h777);
        bus.PCWrite = 1'b0; bus.IFIDWrite = 1'b0; bus.Bolha = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (bus.PC_out !== 32'd0 || bus.IFID_Valid !== 1'b0 || bus.IFID_Instr !== NOP || bus.IFID_PC !== 32'd0) begin
            tests_failed++; $display("FAIL arst_immediate: pc %h v %b instr %h ipc %h", bus.PC_out, bus.IFID_Valid, bus.IFID_Instr, bus.IFID_PC); end
        tests_run++; if (bus.IDEX_Ctrl !== '0 || bus.StallCount !== '0 || bus.FlushCount !== '0) begin
            tests_failed++; $display("FAIL arst_cnt: ctrl %h sc %0d fc %0d", bus.IDEX_Ctrl, bus.StallCount, bus.FlushCount); end
        rst = 1'b0;
        model_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 12'h123);
        tests_run++; if (bus.PC_out !== 32'd4 || bus.IFID_PC !== 32'd0 || bus.IFID_Instr !== imem(32'd0)) begin
            tests_failed++; $display("FAIL arst_resume: pc %h ipc %h instr %h", bus.PC_out, bus.IFID_PC, bus.IFID_Instr); end
    endtask

    task automatic test_random();
        logic pcw, ifw, b, f;
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            b   = ($urandom_range(0, 4) == 0);
            f   = ($urandom_range(0, 6) == 0);
            pcw = b ? 1'b0 : ($urandom_range(0, 7) != 0);
            ifw = b ? 1'b0 : ($urandom_range(0, 7) != 0);
            cyc(pcw, ifw, b, f, $urandom, CTRL_W'($urandom));
            tests_run++; if (bus.PC_out !== m_pc) begin tests_failed++; $display("FAIL rnd_pc@%0d: got %h exp %h", k, bus.PC_out, m_pc); end
            tests_run++; if (bus.IFID_PC !== m_ifid_pc || bus.IFID_Instr !== m_ifid_instr || bus.IFID_Valid !== m_ifid_valid) begin
                tests_failed++; $display("FAIL rnd_ifid@%0d: got %h %h %b exp %h %h %b", k, bus.IFID_PC, bus.IFID_Instr, bus.IFID_Valid, m_ifid_pc, m_ifid_instr, m_ifid_valid); end
            tests_run++; if (bus.IDEX_Ctrl !== m_ctrl) begin tests_failed++; $display("FAIL rnd_ctrl@%0d: got %h exp %h", k, bus.IDEX_Ctrl, m_ctrl); end
            tests_run++; if (int'(bus.StallCount) != m_stalls || int'(bus.FlushCount) != m_flushes) begin
                tests_failed++; $display("FAIL rnd_cnt@%0d: got %0d/%0d exp %0d/%0d", k, bus.StallCount, bus.FlushCount, m_stalls, m_flushes); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_load_use();
        test_jump();
        test_bolha_flush();
        test_wrap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
